// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - op codes, FSM states and op classification for md_sched (MDU_MADD_EN enables accumulate ops)
package md_sched_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Ops that must wait for the unit; undefined codes are treated as NOP.
   function automatic logic is_md_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op >= OP_MULT) && (op <= OP_MSUBU);
`else
      return (op >= OP_MULT) && (op <= OP_MTLO);
`endif
   endfunction

   // Ops that start a multi-cycle operation with the multiply latency.
   function automatic logic is_mult_lat_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == OP_MULT) || (op == OP_MULTU) || ((op >= OP_MADD) && (op <= OP_MSUBU));
`else
      return (op == OP_MULT) || (op == OP_MULTU);
`endif
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/md_sched_arith.sv
// rtl/md_sched_arith.sv - combinational mult/div/accumulate datapath producing the next {hi,lo} (MDU_MADD_EN adds accumulate)
module md_sched_arith
   import md_sched_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [63:0] res_o
);

   logic        signed_mul;
   logic [63:0] mul_a;
   logic [63:0] mul_b;
   logic [63:0] prod;
   logic        neg_x;
   logic        neg_y;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic [63:0] acc;

   // One shared multiplier (sign- or zero-extended operands, low 64 bits) and one
   // magnitude divider; signed division re-applies signs so INT_MIN / -1 wraps cleanly.
   always_comb begin
      signed_mul = (op_i == OP_MULT);
`ifdef MDU_MADD_EN
      signed_mul = signed_mul | (op_i == OP_MADD) | (op_i == OP_MSUB);
`endif
      mul_a = {{32{signed_mul & x_i[31]}}, x_i};
      mul_b = {{32{signed_mul & y_i[31]}}, y_i};
      prod  = mul_a * mul_b;

      neg_x = (op_i == OP_DIV) & x_i[31];
      neg_y = (op_i == OP_DIV) & y_i[31];
      div_a = neg_x ? (32'd0 - x_i) : x_i;
      div_b = (y_i == 32'd0) ? 32'd1 : (neg_y ? (32'd0 - y_i) : y_i);
      quo   = div_a / div_b;
      rem   = div_a % div_b;
      quo_s = (neg_x ^ neg_y) ? (32'd0 - quo) : quo;
      rem_s = neg_x ? (32'd0 - rem) : rem;

      acc   = {hi_i, lo_i};
      res_o = acc;
      case (op_i)
         OP_MULT, OP_MULTU: res_o = prod;
         OP_DIV, OP_DIVU:   res_o = (y_i == 32'd0) ? acc : {rem_s, quo_s};
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU: res_o = acc + prod;
         OP_MSUB, OP_MSUBU: res_o = acc - prod;
`endif
         default:           res_o = acc;
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide sequencer: latency FSM, HI/LO, stall request (MDU_MADD_EN enables MADD/MSUB family)
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [3:0]  op,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);
   localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
   localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_e      state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0] pend_q, pend_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [63:0] arith_res;

   md_sched_arith u_arith (
      .op_i  (op),
      .x_i   (x),
      .y_i   (y),
      .hi_i  (hi_q),
      .lo_i  (lo_q),
      .res_o (arith_res)
   );

   // State, counter, pending result and HI/LO registers; reset overrides any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         pend_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Next state: accept launches in IDLE, count down in BUSY and retire pending on the last count.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               if (is_mult_lat_op(op) || is_div_op(op)) begin
                  pend_d  = arith_res;
                  cnt_d   = is_div_op(op) ? DIV_CNT : MULT_CNT;
                  state_d = ST_BUSY;
               end else if (op == OP_MTHI) begin
                  hi_d = x;
               end else if (op == OP_MTLO) begin
                  lo_d = x;
               end
            end
         end
         ST_BUSY: begin
            if (cnt_q == CNT_ONE) begin
               {hi_d, lo_d} = pend_q;
               cnt_d        = '0;
               state_d      = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
      endcase
   end

   // Stall any MD op while busy, and return HI/LO for move-from ops.
   always_comb begin
      busy  = (state_q == ST_BUSY);
      stall = en & is_md_op(op) & busy;
      rd    = 32'd0;
      if (op == OP_MFHI) begin
         rd = hi_q;
      end else if (op == OP_MFLO) begin
         rd = lo_q;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed and randomized bench for md_sched against a behavioural model (honours MDU_MADD_EN)
module tb_md_sched;
   import md_sched_pkg::*;

   localparam int ML = 5;
   localparam int DL = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [3:0]  op;
   logic [31:0] x;
   logic [31:0] y;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] rd;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic [63:0] m_pend;
   int          m_rem;

   always #5 clk = ~clk;

   md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .op    (op),
      .x     (x),
      .y     (y),
      .busy  (busy),
      .stall (stall),
      .hi    (hi),
      .lo    (lo),
      .rd    (rd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit m_is_md(input logic [3:0] o);
`ifdef MDU_MADD_EN
      return (o >= 1) && (o <= 12);
`else
      return (o >= 1) && (o <= 8);
`endif
   endfunction

   function automatic bit m_is_mul_launch(input logic [3:0] o);
`ifdef MDU_MADD_EN
      return (o == 1) || (o == 2) || ((o >= 9) && (o <= 12));
`else
      return (o == 1) || (o == 2);
`endif
   endfunction

   function automatic logic [63:0] m_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] h, input logic [31:0] l);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     acc, ps, pu;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      acc = {h, l};
      ps  = sa * sb;
      pu  = ua * ub;
      case (o)
         4'd1: return ps;
         4'd2: return pu;
         4'd3: begin
            if (b == 32'd0) return acc;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 32'd0) return acc;
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         4'd9:  return acc + ps;
         4'd10: return acc + pu;
         4'd11: return acc - ps;
         4'd12: return acc - pu;
         default: return acc;
      endcase
   endfunction

   // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
   task automatic step(input bit e, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] rd_exp;
      en = e;
      op = o;
      x  = a;
      y  = b;
      #2;
      check("stall", {31'd0, stall}, {31'd0, (e && m_is_md(o) && m_rem > 0)});
      rd_exp = (o == 4'd5) ? m_hi : ((o == 4'd6) ? m_lo : 32'd0);
      check("rd", rd, rd_exp);
      if (!rst) begin
         m_hi = 0; m_lo = 0; m_pend = 0; m_rem = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) {m_hi, m_lo} = m_pend;
      end else if (e) begin
         if (m_is_mul_launch(o)) begin
            m_pend = m_result(o, a, b, m_hi, m_lo);
            m_rem  = ML;
         end else if (o == 4'd3 || o == 4'd4) begin
            m_pend = m_result(o, a, b, m_hi, m_lo);
            m_rem  = DL;
         end else if (o == 4'd7) begin
            m_hi = a;
         end else if (o == 4'd8) begin
            m_lo = a;
         end
      end
      @(posedge clk);
      #1;
      check("busy", {31'd0, busy}, {31'd0, (m_rem > 0)});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, OP_NOP, 32'd0, 32'd0);
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; op = OP_NOP; x = 0; y = 0;
      m_hi = 0; m_lo = 0; m_pend = 0; m_rem = 0;
      @(posedge clk);
      #1;
      idle(2);
      rst = 1'b1;

      // reset in the middle of a divide
      step(1'b1, OP_MTHI, 32'hAAAA, 32'd0);
      step(1'b1, OP_DIV, 32'd100, 32'd7);
      idle(3);
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      check("t1_busy", {31'd0, busy}, 32'd0);
      check("t1_hi", hi, 32'd0);
      step(1'b1, OP_MULT, 32'd6, 32'd7);
      check("t1_accept", {31'd0, busy}, 32'd1);
      idle(5);

      // signed and unsigned multiply
      step(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3);
      idle(5);
      check("t2_mult_hi", hi, 32'hFFFFFFFF);
      check("t2_mult_lo", lo, 32'hFFFFFFFA);
      step(1'b1, OP_MULTU, 32'hFFFFFFFE, 32'd3);
      idle(5);
      check("t2_multu_hi", hi, 32'd2);
      check("t2_multu_lo", lo, 32'hFFFFFFFA);

      // division corners
      step(1'b1, OP_DIV, 32'hFFFFFFF9, 32'd2);
      idle(10);
      check("t3_div_lo", lo, 32'hFFFFFFFD);
      check("t3_div_hi", hi, 32'hFFFFFFFF);
      step(1'b1, OP_DIV, 32'h80000000, 32'hFFFFFFFF);
      idle(10);
      check("t3_ovf_lo", lo, 32'h80000000);
      check("t3_ovf_hi", hi, 32'd0);
      step(1'b1, OP_DIVU, 32'd55, 32'd0);
      idle(10);
      check("t3_div0_lo", lo, 32'h80000000);
      check("t3_div0_hi", hi, 32'd0);

      // MFLO waits behind a divide; non-MD ops pass while busy
      step(1'b1, OP_DIV, 32'd100, 32'd7);
      step(1'b1, OP_MFLO, 32'd0, 32'd0);
      step(1'b1, OP_NOP, 32'd0, 32'd0);
      step(1'b1, 4'd13, 32'd0, 32'd0);
      for (int i = 0; i < 7; i++) step(1'b1, OP_MFLO, 32'd0, 32'd0);
      en = 1'b1; op = OP_MFLO; #2;
      check("t4_stall_done", {31'd0, stall}, 32'd0);
      check("t4_rd", rd, 32'd14);
      step(1'b1, OP_MFLO, 32'd0, 32'd0);

      // move-to / move-from, and disabled ops
      step(1'b1, OP_MTHI, 32'h1234, 32'd0);
      step(1'b1, OP_MFHI, 32'd0, 32'd0);
      check("t5_rd", rd, 32'h1234);
      check("t5_busy", {31'd0, busy}, 32'd0);
      step(1'b0, OP_MULT, 32'd5, 32'd5);
      check("t5_en0", {31'd0, busy}, 32'd0);

      // accumulate
      step(1'b1, OP_MTHI, 32'd0, 32'd0);
      step(1'b1, OP_MTLO, 32'hFFFFFFFF, 32'd0);
      step(1'b1, OP_MADDU, 32'd1, 32'd1);
      idle(5);
`ifdef MDU_MADD_EN
      check("t6_hi", hi, 32'd1);
      check("t6_lo", lo, 32'd0);
`else
      check("t6_hi", hi, 32'd0);
      check("t6_lo", lo, 32'hFFFFFFFF);
`endif

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] a, b;
         logic [3:0]  o;
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 5);
         if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
         o = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
         step($urandom_range(0, 3) != 0, o, a, b);
         rst = 1'b1;
      end
      idle(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
